// File: rtl/sd_init_sequencer.sv
// sd_init_sequencer
//   Brings an SD card up in SPI mode: 0xFF dummy bytes with CS high, then
//   CMD0, CMD8 (with R7 trailer check), and the CMD55/ACMD41 loop until the
//   card leaves idle.  Every byte goes through an external byte shifter using
//   a start/done handshake with at most one byte outstanding.
// Ports
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                begin init (honoured only when not busy)
//   o_spi_start            one-cycle request to shift o_spi_tx_byte
//   o_spi_tx_byte          byte to shift, held until i_spi_done
//   i_spi_done             byte finished; i_spi_rx_byte valid this cycle
//   i_spi_rx_byte          byte received from the card
//   o_cs_n                 card chip select, active low
//   o_clk_mode             shifter clock select: 0 slow (400 kHz), 1 fast
//   o_busy/o_ready/o_error sequence status
//   o_err_code             1 CMD0, 2 CMD8, 3 ACMD41 limit, 4 ACMD41 R1, 5 CMD55
module sd_init_sequencer #(
   parameter int DUMMY_BYTES = 10,
   parameter int NCR_MAX     = 8,
   parameter int ACMD41_MAX  = 1000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   output logic       o_spi_start,
   output logic [7:0] o_spi_tx_byte,
   input  logic       i_spi_done,
   input  logic [7:0] i_spi_rx_byte,
   output logic       o_cs_n,
   output logic       o_clk_mode,
   output logic       o_busy,
   output logic       o_ready,
   output logic       o_error,
   output logic [2:0] o_err_code
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_DUMMY, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_DONE, ST_ERROR
   } state_t;

   // Sub-phase inside a command state.
   typedef enum logic [1:0] {PH_FRAME, PH_POLL, PH_TRAIL, PH_GAP} phase_t;

   localparam logic [7:0]  DUMMY_LAST = 8'(DUMMY_BYTES - 1);
   localparam logic [7:0]  POLL_LAST  = 8'(NCR_MAX - 1);
   localparam logic [15:0] ACMD_MAX16 = 16'(ACMD41_MAX);

   state_t      state, state_n, gap_tgt, gap_tgt_n;
   phase_t      phase, phase_n;
   logic [7:0]  cnt, cnt_n;
   logic [7:0]  poll_cnt, poll_n;
   logic [15:0] attempts, att_n;
   logic        trail_ok, trail_ok_n;
   logic        spi_start, spi_start_n;
   logic [7:0]  tx_byte, tx_n;
   logic        cs_n, cs_n_n;
   logic        clk_mode, clk_mode_n;
   logic [2:0]  err_code, err_n;
   logic        fail, go_gap;
   logic [2:0]  fail_code;

   // Six-byte command frames (index, argument, CRC).
   function automatic logic [7:0] frame_byte(input state_t s, input logic [2:0] i);
      logic [7:0] b;
      b = 8'h00;
      case (s)
         ST_CMD0:   case (i) 3'd0: b = 8'h40; 3'd5: b = 8'h95; default: b = 8'h00; endcase
         ST_CMD8:   case (i) 3'd0: b = 8'h48; 3'd3: b = 8'h01; 3'd4: b = 8'hAA;
                             3'd5: b = 8'h87; default: b = 8'h00; endcase
         ST_CMD55:  case (i) 3'd0: b = 8'h77; 3'd5: b = 8'h01; default: b = 8'h00; endcase
         ST_ACMD41: case (i) 3'd0: b = 8'h69; 3'd1: b = 8'h40; 3'd5: b = 8'h01;
                             default: b = 8'h00; endcase
         default:   b = 8'hFF;
      endcase
      return b;
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= ST_IDLE;
         phase     <= PH_FRAME;
         gap_tgt   <= ST_IDLE;
         cnt       <= 8'd0;
         poll_cnt  <= 8'd0;
         attempts  <= 16'd0;
         trail_ok  <= 1'b0;
         spi_start <= 1'b0;
         tx_byte   <= 8'hFF;
         cs_n      <= 1'b1;
         clk_mode  <= 1'b0;
         err_code  <= 3'd0;
      end else begin
         state     <= state_n;
         phase     <= phase_n;
         gap_tgt   <= gap_tgt_n;
         cnt       <= cnt_n;
         poll_cnt  <= poll_n;
         attempts  <= att_n;
         trail_ok  <= trail_ok_n;
         spi_start <= spi_start_n;
         tx_byte   <= tx_n;
         cs_n      <= cs_n_n;
         clk_mode  <= clk_mode_n;
         err_code  <= err_n;
      end
   end

   // Every byte is issued on the edge that retires the previous one, so the
   // shifter always has exactly one byte in flight while busy and i_spi_done
   // is only acted on in the busy states.
   always_comb begin
      state_n     = state;
      phase_n     = phase;
      gap_tgt_n   = gap_tgt;
      cnt_n       = cnt;
      poll_n      = poll_cnt;
      att_n       = attempts;
      trail_ok_n  = trail_ok;
      spi_start_n = 1'b0;
      tx_n        = tx_byte;
      cs_n_n      = cs_n;
      clk_mode_n  = clk_mode;
      err_n       = err_code;
      fail        = 1'b0;
      fail_code   = 3'd0;
      go_gap      = 1'b0;

      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) begin
               state_n     = ST_DUMMY;
               phase_n     = PH_FRAME;
               cnt_n       = 8'd0;
               poll_n      = 8'd0;
               att_n       = 16'd0;
               err_n       = 3'd0;
               clk_mode_n  = 1'b0;
               cs_n_n      = 1'b1;
               spi_start_n = 1'b1;
               tx_n        = 8'hFF;
            end
         end

         ST_DUMMY: begin
            if (i_spi_done) begin
               spi_start_n = 1'b1;
               if (cnt == DUMMY_LAST) begin
                  state_n = ST_CMD0;
                  phase_n = PH_FRAME;
                  cnt_n   = 8'd0;
                  cs_n_n  = 1'b0;
                  tx_n    = frame_byte(ST_CMD0, 3'd0);
               end else begin
                  cnt_n = cnt + 8'd1;
                  tx_n  = 8'hFF;
               end
            end
         end

         ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41: begin
            if (i_spi_done) begin
               case (phase)
                  PH_FRAME: begin
                     spi_start_n = 1'b1;
                     if (cnt == 8'd5) begin
                        phase_n = PH_POLL;
                        poll_n  = 8'd0;
                        tx_n    = 8'hFF;
                     end else begin
                        cnt_n = cnt + 8'd1;
                        tx_n  = frame_byte(state, cnt[2:0] + 3'd1);
                     end
                  end

                  PH_POLL: begin
                     if (i_spi_rx_byte == 8'hFF) begin
                        if (poll_cnt == POLL_LAST) begin
                           fail = 1'b1;
                           case (state)
                              ST_CMD0:  fail_code = 3'd1;
                              ST_CMD8:  fail_code = 3'd2;
                              ST_CMD55: fail_code = 3'd5;
                              default:  fail_code = 3'd4;
                           endcase
                        end else begin
                           poll_n      = poll_cnt + 8'd1;
                           spi_start_n = 1'b1;
                           tx_n        = 8'hFF;
                        end
                     end else begin
                        case (state)
                           ST_CMD0: begin
                              if (i_spi_rx_byte == 8'h01) begin
                                 go_gap = 1'b1; gap_tgt_n = ST_CMD8;
                              end else begin
                                 fail = 1'b1; fail_code = 3'd1;
                              end
                           end
                           ST_CMD8: begin
                              if (i_spi_rx_byte == 8'h01) begin
                                 phase_n     = PH_TRAIL;
                                 cnt_n       = 8'd0;
                                 spi_start_n = 1'b1;
                                 tx_n        = 8'hFF;
                              end else begin
                                 fail = 1'b1; fail_code = 3'd2;
                              end
                           end
                           ST_CMD55: begin
                              if (i_spi_rx_byte == 8'h01 || i_spi_rx_byte == 8'h00) begin
                                 go_gap = 1'b1; gap_tgt_n = ST_ACMD41;
                              end else begin
                                 fail = 1'b1; fail_code = 3'd5;
                              end
                           end
                           default: begin
                              if (i_spi_rx_byte == 8'h00) begin
                                 go_gap = 1'b1; gap_tgt_n = ST_DONE;
                              end else if (i_spi_rx_byte == 8'h01) begin
                                 att_n = attempts + 16'd1;
                                 if (attempts + 16'd1 >= ACMD_MAX16) begin
                                    fail = 1'b1; fail_code = 3'd3;
                                 end else begin
                                    go_gap = 1'b1; gap_tgt_n = ST_CMD55;
                                 end
                              end else begin
                                 fail = 1'b1; fail_code = 3'd4;
                              end
                           end
                        endcase
                     end
                  end

                  // CMD8 R7 trailer: byte3 carries the voltage field, byte4 the echo.
                  PH_TRAIL: begin
                     if (cnt == 8'd2) trail_ok_n = (i_spi_rx_byte[3:0] == 4'h1);
                     if (cnt == 8'd3) begin
                        if (trail_ok && i_spi_rx_byte == 8'hAA) begin
                           go_gap = 1'b1; gap_tgt_n = ST_CMD55;
                        end else begin
                           fail = 1'b1; fail_code = 3'd2;
                        end
                     end else begin
                        cnt_n       = cnt + 8'd1;
                        spi_start_n = 1'b1;
                        tx_n        = 8'hFF;
                     end
                  end

                  default: begin // PH_GAP: trailing 0xFF with CS high is finished
                     if (gap_tgt == ST_DONE) begin
                        state_n    = ST_DONE;
                        clk_mode_n = 1'b1;
                     end else begin
                        state_n     = gap_tgt;
                        phase_n     = PH_FRAME;
                        cnt_n       = 8'd0;
                        cs_n_n      = 1'b0;
                        spi_start_n = 1'b1;
                        tx_n        = frame_byte(gap_tgt, 3'd0);
                     end
                  end
               endcase
            end
         end

         default: state_n = ST_IDLE;
      endcase

      if (go_gap) begin
         phase_n     = PH_GAP;
         cs_n_n      = 1'b1;
         spi_start_n = 1'b1;
         tx_n        = 8'hFF;
      end
      if (fail) begin
         state_n     = ST_ERROR;
         cs_n_n      = 1'b1;
         clk_mode_n  = 1'b0;
         err_n       = fail_code;
         spi_start_n = 1'b0;
      end
   end

   assign o_spi_start   = spi_start;
   assign o_spi_tx_byte = tx_byte;
   assign o_cs_n        = cs_n;
   assign o_clk_mode    = clk_mode;
   assign o_err_code    = err_code;
   assign o_busy        = (state == ST_DUMMY) || (state == ST_CMD0) || (state == ST_CMD8) ||
                          (state == ST_CMD55) || (state == ST_ACMD41);
   assign o_ready       = (state == ST_DONE);
   assign o_error       = (state == ST_ERROR);

endmodule

// File: tb/tb_sd_init_sequencer.sv
// tb_sd_init_sequencer
//   Bench for sd_init_sequencer.  Each scenario lists the byte transfers the
//   card must see (tx byte, CS level) together with the byte the card answers.
//   A card process serves the handshake from that list and checks every
//   o_spi_start against it; the main process drives i_start/reset and checks
//   the final status flags.
`timescale 1ns/1ps
module tb_sd_init_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       spi_done = 1'b0;
   logic [7:0] rx_byte = 8'hFF;
   logic       spi_start, cs_n, clk_mode, busy, ready, error;
   logic [7:0] tx_byte;
   logic [2:0] err_code;

   always #5 clk = ~clk;

   sd_init_sequencer #(.DUMMY_BYTES(10), .NCR_MAX(8), .ACMD41_MAX(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .o_spi_start(spi_start), .o_spi_tx_byte(tx_byte),
      .i_spi_done(spi_done), .i_spi_rx_byte(rx_byte),
      .o_cs_n(cs_n), .o_clk_mode(clk_mode), .o_busy(busy),
      .o_ready(ready), .o_error(error), .o_err_code(err_code)
   );

   typedef struct {
      logic [7:0] tx;
      logic       cs;
      logic [7:0] rx;
   } xfer_t;

   xfer_t expq[$];
   int tests = 0;
   int fails = 0;
   int nsent = 0;    // bytes issued by the DUT (cumulative)
   int n_cmd55 = 0;  // CMD55 frames seen (cumulative)
   int n_cshi = 0;   // bytes issued with CS high (cumulative)

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] cmd_byte(input int c, input int i);
      logic [7:0] f [6];
      case (c)
         0:       f = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
         1:       f = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
         2:       f = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
         default: f = '{8'h69, 8'h40, 8'h00, 8'h00, 8'h00, 8'h01};
      endcase
      return f[i];
   endfunction

   task automatic push(input logic [7:0] tx, input logic cs, input logic [7:0] r);
      xfer_t e;
      e.tx = tx; e.cs = cs; e.rx = r;
      expq.push_back(e);
   endtask

   task automatic q_dummy();
      for (int i = 0; i < 10; i++) push(8'hFF, 1'b1, 8'hFF);
   endtask

   task automatic q_gap();
      push(8'hFF, 1'b1, 8'hFF);
   endtask

   // c: 0 CMD0, 1 CMD8, 2 CMD55, 3 ACMD41; nff idle polls before the R1
   task automatic q_cmd(input int c, input int nff, input logic [7:0] r1, input bit give_r1);
      for (int i = 0; i < 6; i++) push(cmd_byte(c, i), 1'b0, 8'hFF);
      for (int i = 0; i < nff; i++) push(8'hFF, 1'b0, 8'hFF);
      if (give_r1) push(8'hFF, 1'b0, r1);
   endtask

   task automatic q_trailer(input logic [7:0] b3, input logic [7:0] b4);
      push(8'hFF, 1'b0, 8'h00);
      push(8'hFF, 1'b0, 8'h00);
      push(8'hFF, 1'b0, b3);
      push(8'hFF, 1'b0, b4);
   endtask

   task automatic q_prefix();
      q_dummy();
      q_cmd(0, 0, 8'h01, 1'b1); q_gap();
      q_cmd(1, 1, 8'h01, 1'b1); q_trailer(8'h01, 8'hAA); q_gap();
   endtask

   // n01 ACMD41 attempts answered 0x01, then one answered 0x00
   task automatic q_success(input int n01);
      q_dummy();
      q_cmd(0, 1, 8'h01, 1'b1); q_gap();
      q_cmd(1, 0, 8'h01, 1'b1); q_trailer(8'h01, 8'hAA); q_gap();
      for (int i = 0; i < n01; i++) begin
         q_cmd(2, 0, 8'h01, 1'b1); q_gap();
         q_cmd(3, 0, 8'h01, 1'b1); q_gap();
      end
      q_cmd(2, 0, 8'h01, 1'b1); q_gap();
      q_cmd(3, 0, 8'h00, 1'b1); q_gap();
   endtask

   // Card side: serve each request after a short variable delay, check it
   // against the expected list, and flag overlapping requests.
   initial begin : card
      bit         pend;
      int         dly;
      logic [7:0] cur_rx;
      xfer_t      e;
      pend = 1'b0; dly = 0; cur_rx = 8'hFF;
      forever begin
         @(negedge clk);
         spi_done = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
            continue;
         end
         if (spi_start) begin
            chk("one_outstanding", pend, 1'b0);
            if (expq.size() == 0) begin
               chk($sformatf("unexpected_byte[%0d]", nsent), tx_byte, 32'hFFFF_FFFF);
               cur_rx = 8'hFF;
            end else begin
               e = expq.pop_front();
               chk($sformatf("tx_byte[%0d]", nsent), tx_byte, e.tx);
               chk($sformatf("cs_n[%0d]", nsent), cs_n, e.cs);
               cur_rx = e.rx;
            end
            if (tx_byte == 8'h77 && !cs_n) n_cmd55++;
            if (cs_n) n_cshi++;
            nsent++;
            pend = 1'b1;
            dly  = nsent % 3;
         end else if (pend) begin
            if (dly == 0) begin
               spi_done = 1'b1;
               rx_byte  = cur_rx;
               pend     = 1'b0;
            end else begin
               dly--;
            end
         end
      end
   end

   task automatic pulse_start(input bit expect_issue);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (expect_issue) begin
         chk("start_latency_spi_start", spi_start, 1'b1);
         chk("start_latency_busy", busy, 1'b1);
         chk("start_clears_ready", ready, 1'b0);
         chk("start_clears_error", error, 1'b0);
         chk("start_clears_err_code", err_code, 3'd0);
         chk("start_clk_mode_slow", clk_mode, 1'b0);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      for (k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk({name, "_finished_in_time"}, (k < 5000), 1'b1);
      repeat (12) @(negedge clk);
      chk({name, "_all_bytes_sent"}, expq.size(), 0);
   endtask

   task automatic chk_status(input string name, input logic rdy, input logic err,
                             input logic [2:0] code, input logic fast);
      chk({name, "_ready"}, ready, rdy);
      chk({name, "_error"}, error, err);
      chk({name, "_err_code"}, err_code, code);
      chk({name, "_clk_mode"}, clk_mode, fast);
      chk({name, "_cs_n"}, cs_n, 1'b1);
      chk({name, "_busy"}, busy, 1'b0);
   endtask

   task automatic wait_sent(input int target);
      int k;
      for (k = 0; k < 2000; k++) begin
         if (nsent >= target) break;
         @(negedge clk);
      end
      chk("reached_byte_index", (k < 2000), 1'b1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 500000 ns");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int base, b55, bhi;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_cs_n", cs_n, 1'b1);
      chk("rst_clk_mode", clk_mode, 1'b0);
      chk("rst_spi_start", spi_start, 1'b0);
      chk("rst_tx_byte", tx_byte, 8'hFF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", ready, 1'b0);
      chk("rst_error", error, 1'b0);
      chk("rst_err_code", err_code, 3'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full init: ACMD41 answers 01, 01, 00
      q_success(2);
      base = nsent; b55 = n_cmd55; bhi = n_cshi;
      pulse_start(1'b1);
      chk("first_byte_dummy", tx_byte, 8'hFF);
      wait_idle("ok");
      chk_status("ok", 1'b1, 1'b0, 3'd0, 1'b1);
      chk("ok_total_bytes", nsent - base, 79);
      chk("ok_cmd55_frames", n_cmd55 - b55, 3);
      chk("ok_cs_high_bytes", n_cshi - bhi, 18);

      // CMD0 never answers: 6 frame bytes + 8 polls, then code 1
      q_dummy(); q_cmd(0, 8, 8'hFF, 1'b0);
      base = nsent;
      pulse_start(1'b1);
      wait_idle("cmd0_timeout");
      chk_status("cmd0_timeout", 1'b0, 1'b1, 3'd1, 1'b0);
      chk("cmd0_timeout_bytes", nsent - base, 24);

      // CMD0 wrong R1
      q_dummy(); q_cmd(0, 2, 8'h00, 1'b1);
      pulse_start(1'b1);
      wait_idle("cmd0_bad");
      chk_status("cmd0_bad", 1'b0, 1'b1, 3'd1, 1'b0);

      // CMD8 echo wrong; i_start pulsed mid-CMD8 must not disturb anything
      q_dummy(); q_cmd(0, 0, 8'h01, 1'b1); q_gap();
      q_cmd(1, 0, 8'h01, 1'b1); q_trailer(8'h01, 8'h55);
      base = nsent; b55 = n_cmd55;
      pulse_start(1'b1);
      wait_sent(base + 20);
      pulse_start(1'b0);
      wait_idle("cmd8_echo");
      chk_status("cmd8_echo", 1'b0, 1'b1, 3'd2, 1'b0);
      chk("cmd8_echo_no_cmd55", n_cmd55 - b55, 0);

      // Restart from ERROR
      q_success(1);
      pulse_start(1'b1);
      wait_idle("rerun");
      chk_status("rerun", 1'b1, 1'b0, 3'd0, 1'b1);

      // CMD55 bad R1
      q_prefix(); q_cmd(2, 0, 8'h05, 1'b1);
      pulse_start(1'b1);
      wait_idle("cmd55_bad");
      chk_status("cmd55_bad", 1'b0, 1'b1, 3'd5, 1'b0);

      // ACMD41 bad R1
      q_prefix(); q_cmd(2, 0, 8'h00, 1'b1); q_gap(); q_cmd(3, 1, 8'h04, 1'b1);
      pulse_start(1'b1);
      wait_idle("acmd41_bad");
      chk_status("acmd41_bad", 1'b0, 1'b1, 3'd4, 1'b0);

      // ACMD41 stuck at 0x01: exactly 4 attempts
      q_prefix();
      for (int i = 0; i < 4; i++) begin
         q_cmd(2, 0, 8'h01, 1'b1); q_gap();
         q_cmd(3, 0, 8'h01, 1'b1);
         if (i < 3) q_gap();
      end
      b55 = n_cmd55;
      pulse_start(1'b1);
      wait_idle("acmd41_limit");
      chk_status("acmd41_limit", 1'b0, 1'b1, 3'd3, 1'b0);
      chk("acmd41_limit_attempts", n_cmd55 - b55, 4);

      // Reset while polling for the ACMD41 R1
      q_prefix(); q_cmd(2, 0, 8'h01, 1'b1); q_gap(); q_cmd(3, 5, 8'h00, 1'b1); q_gap();
      base = nsent;
      pulse_start(1'b1);
      wait_sent(base + 47);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_cs_n", cs_n, 1'b1);
      chk("async_rst_clk_mode", clk_mode, 1'b0);
      chk("async_rst_spi_start", spi_start, 1'b0);
      chk("async_rst_tx_byte", tx_byte, 8'hFF);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_ready", ready, 1'b0);
      chk("async_rst_error", error, 1'b0);
      chk("async_rst_err_code", err_code, 3'd0);
      expq.delete();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      base = nsent;
      repeat (10) @(negedge clk);
      chk("after_rst_no_bytes", nsent - base, 0);
      q_success(2);
      pulse_start(1'b1);
      chk("after_rst_first_byte_dummy", tx_byte, 8'hFF);
      wait_idle("after_rst");
      chk_status("after_rst", 1'b1, 1'b0, 3'd0, 1'b1);
      chk("after_rst_total_bytes", nsent - base, 79);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
